fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the single-cycle datapath. Owns the PC and issues word fetches to instruction memory over a req/gnt/rvalid handshake. Buffers returned words in a small FIFO and presents {instr, pc} to the datapath with a valid/ready handshake. Computes redirect targets (branch, jump, jr) from datapath feedback and flushes wrong-path work.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
BUF_DEPTH, 2, instruction buffer entries (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request
imem_addr  out  32  word-aligned fetch address
imem_gnt  in  1  request accepted this cycle when imem_req=1
imem_rvalid  in  1  read data valid
imem_rdata  in  32  read data
instr  out  32  buffer head instruction
instr_pc  out  32  PC of instr
instr_valid  out  1  head entry valid
instr_ready  in  1  datapath consumes head
redir_branch  in  1  conditional branch resolved taken
redir_jump  in  1  j/jal
redir_jr  in  1  jr
redir_pc  in  32  PC of the redirecting instruction
redir_imm  in  16  branch offset (words)
redir_jaddr  in  26  jump target field
redir_rs_val  in  32  jr target register value

Behaviour:
- Reset (rst=0, async): pc_q=RESET_PC; buffer empty; no outstanding request; discard flag=0; imem_req=0, instr_valid=0, instr=0, instr_pc=0. First imem_req=1 occurs in the first cycle after rst deasserts.
- FSM: S_IDLE (no request), S_REQ (imem_req=1, imem_addr=pc_q), S_WAIT (one request outstanding, awaiting rvalid). Only one outstanding request at a time.
- S_IDLE->S_REQ when count+outstanding < BUF_DEPTH. S_REQ->S_WAIT on imem_gnt; pc_q <= pc_q+4 in that cycle. S_WAIT->S_REQ on imem_rvalid if buffer space remains after push, else ->S_IDLE.
- imem_req/imem_addr may change while not granted; a request counts only in a cycle with imem_req&imem_gnt. rvalid arrives >=1 cycle after grant.
- Buffer push on imem_rvalid with discard=0: {imem_rdata, fetch_pc}. Pop on instr_valid&instr_ready. Simultaneous push and pop at full: allowed, count unchanged. Push at full cannot occur (request gating).
- Latency: reset-release to first instr_valid = 2 cycles plus memory latency (gnt same cycle, rvalid next → instr_valid the cycle after rvalid).
- Redirect target, priority jr > jump > branch:
  - jr: redir_rs_val with bits [1:0] forced to 0.
  - jump: {redir_pc+4 [31:28], redir_jaddr, 2'b00}.
  - branch: redir_pc+4 + (sign_extend(redir_imm)<<2), modulo 2^32.
  - No delay slot.
- Any redirect input high, same cycle: buffer flushed (count=0, including head even if popped that cycle); pc_q <= target.
  - In S_REQ without gnt: -> S_REQ at target next cycle.
  - In S_REQ with gnt, or in S_WAIT without rvalid: discard=1, -> S_WAIT.
  - In S_WAIT with rvalid: returned word dropped, -> S_REQ.
- While discard=1, the next rvalid is dropped, discard clears, -> S_REQ. New redirect while discard=1: only pc_q updates.
- instr/instr_pc hold the last head value when instr_valid=0. Reset mid-operation abandons any outstanding request; a later stray rvalid in S_IDLE/S_REQ is ignored.

Decomposition:
- Shared package mips_pkg: fetch FSM state enum, INSTR_W=32, PC_INCR=4, RESET_PC default.
- One sub-module: fetch_fifo (parameterised depth, width 64 = {pc, instr}; push/pop/flush/count). Target arithmetic and FSM stay in fetch_unit.

Test Plan:
- Reset release, memory gnt=1 and rvalid one cycle later, instr_ready=1 → instr_pc sequence 0x0,0x4,0x8; instr matches memory image; at most one request outstanding at any time.
- instr_ready=0 for 10 cycles → exactly BUF_DEPTH=2 entries buffered, imem_req=0; ready=1 → PCs 0x0,0x4 in order, no loss or duplication.
- redir_branch with redir_pc=0x10, redir_imm=16'hFFFC while S_WAIT → in-flight word dropped, next instr_pc=0x4.
- redir_jump redir_pc=0xF000_0040, redir_jaddr=26'h0000100, plus redir_branch same cycle → jump wins, next instr_pc=0xF000_0400. redir_jr rs_val=0x203 → next instr_pc=0x200.
- gnt held 0 for 5 cycles, then redirect to 0x80 → imem_addr=0x80 next cycle, old address never granted, no discard.
- rst asserted while S_WAIT, stray rvalid during reset and after release → outputs at reset values, stray word not pushed, first instr_pc=RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage types and constants
package mips_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage memory, instruction and redirect signals
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  logic        redir_branch;
  logic        redir_jump;
  logic        redir_jr;
  logic [31:0] redir_pc;
  logic [15:0] redir_imm;
  logic [25:0] redir_jaddr;
  logic [31:0] redir_rs_val;

  // fetch unit side
  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    input  redir_branch, redir_jump, redir_jr, redir_pc, redir_imm,
    input  redir_jaddr, redir_rs_val
  );

  // memory / datapath side
  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    output redir_branch, redir_jump, redir_jr, redir_pc, redir_imm,
    output redir_jaddr, redir_rs_val
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small instruction buffer with flush
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  // pop only a real entry; push at full is allowed only alongside a pop
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count < CNT_W'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  // pointer and occupancy tracking; flush empties the buffer outright
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // storage write; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, instruction fetch FSM and redirect handling
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int CNT_W   = $clog2(BUF_DEPTH) + 1;
  localparam int ENTRY_W = 2 * INSTR_W;

  fetch_state_t       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic               discard_q, discard_d;
  logic               any_redir;
  logic [31:0]        seq_pc;
  logic [31:0]        target;
  logic               push;
  logic               pop;
  logic               head_valid;
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] last_head_q;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_after;

  assign any_redir   = bus.redir_branch | bus.redir_jump | bus.redir_jr;
  assign head_valid  = (count != '0);
  assign pop         = head_valid & bus.instr_ready;
  // occupancy if the returning word is pushed this cycle
  assign count_after = count + CNT_W'(1) - CNT_W'(pop);

  // redirect target, jr beats jump beats branch
  always_comb begin
    seq_pc = bus.redir_pc + PC_INCR;
    if (bus.redir_jr) begin
      target = {bus.redir_rs_val[31:2], 2'b00};
    end else if (bus.redir_jump) begin
      target = {seq_pc[31:28], bus.redir_jaddr, 2'b00};
    end else begin
      target = seq_pc + {{14{bus.redir_imm[15]}}, bus.redir_imm, 2'b00};
    end
  end

  // next-state, PC and discard logic
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    push       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_redir || (count < CNT_W'(BUF_DEPTH))) state_d = S_REQ;
      end
      S_REQ: begin
        if (bus.imem_gnt) begin
          fetch_pc_d = pc_q;
          pc_d       = pc_q + PC_INCR;
          state_d    = S_WAIT;
          if (any_redir) discard_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          discard_d = 1'b0;
          if (discard_q || any_redir) begin
            state_d = S_REQ;
          end else begin
            push    = 1'b1;
            state_d = (count_after < CNT_W'(BUF_DEPTH)) ? S_REQ : S_IDLE;
          end
        end else if (any_redir) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (any_redir) pc_d = target;
  end

  // state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      fetch_pc_q <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end

  // remember the head so outputs hold steady while the buffer is empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_head_q <= '0;
    end else if (head_valid) begin
      last_head_q <= head;
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({fetch_pc_q, bus.imem_rdata}),
    .pop       (pop),
    .flush     (any_redir),
    .head      (head),
    .count     (count)
  );

  assign bus.imem_req    = (state_q == S_REQ);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = head_valid;
  assign bus.instr       = head_valid ? head[INSTR_W-1:0]       : last_head_q[INSTR_W-1:0];
  assign bus.instr_pc    = head_valid ? head[ENTRY_W-1:INSTR_W] : last_head_q[ENTRY_W-1:INSTR_W];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          lat      = 1;
  bit          gnt_en   = 1'b0;
  int          stray_cnt = 0;
  int          grant_cnt = 0;
  logic [31:0] first_gnt_addr = '0;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;

  function automatic logic [31:0] img(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = img(pc);
    exp_q.push_back(e);
  endtask

  task automatic clear_redir();
    bus.redir_branch = 1'b0;
    bus.redir_jump   = 1'b0;
    bus.redir_jr     = 1'b0;
    bus.redir_pc     = '0;
    bus.redir_imm    = '0;
    bus.redir_jaddr  = '0;
    bus.redir_rs_val = '0;
  endtask

  task automatic apply_reset(input int l, input bit g);
    @(negedge clk);
    rst = 1'b0;
    bus.instr_ready = 1'b0;
    clear_redir();
    repeat (5) @(negedge clk);
    exp_q.delete();
    lat       = l;
    gnt_en    = g;
    grant_cnt = 0;
    rst       = 1'b1;
  endtask

  task automatic wait_empty(input string name);
    int c = 0;
    while (exp_q.size() != 0 && c < 300) begin
      @(negedge clk);
      c++;
    end
    check32({name, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_grants(input int n);
    int c = 0;
    while (grant_cnt < n && c < 100) begin
      @(negedge clk);
      c++;
    end
    check32("grant_wait", 32'(grant_cnt >= n), 32'd1);
  endtask

  // drive one redirect cycle, then clear
  task automatic redirect(input bit br, input bit jmp, input bit jr, input logic [31:0] rpc,
                          input logic [15:0] imm, input logic [25:0] ja, input logic [31:0] rs);
    bus.redir_branch = br;
    bus.redir_jump   = jmp;
    bus.redir_jr     = jr;
    bus.redir_pc     = rpc;
    bus.redir_imm    = imm;
    bus.redir_jaddr  = ja;
    bus.redir_rs_val = rs;
    @(negedge clk);
    clear_redir();
  endtask

  // memory model: grant policy, fixed-latency response, stray injection
  initial begin
    forever begin
      @(negedge clk);
      #1;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      if (stray_cnt > 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        stray_cnt--;
      end else if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = img(pend_addr);
          pend = 1'b0;
        end
      end
      bus.imem_gnt = gnt_en;
      if (bus.imem_req && gnt_en) begin
        check32("one_outstanding", 32'(pend), 32'd0);
        pend      = 1'b1;
        pend_cnt  = lat;
        pend_addr = bus.imem_addr;
        if (grant_cnt == 0) first_gnt_addr = bus.imem_addr;
        grant_cnt++;
      end
    end
  end

  // monitor: compare every consumed head against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst && bus.instr_valid && bus.instr_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_instr: got pc %h instr %h expected none", bus.instr_pc, bus.instr);
        end else begin
          e = exp_q.pop_front();
          check32("instr_pc", bus.instr_pc, e.pc);
          check32("instr", bus.instr, e.instr);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

  initial begin
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.instr_ready = 1'b0;
    clear_redir();

    // reset state and basic streaming
    repeat (2) @(negedge clk);
    check32("rst_req", 32'(bus.imem_req), 32'd0);
    check32("rst_valid", 32'(bus.instr_valid), 32'd0);
    check32("rst_instr", bus.instr, 32'd0);
    check32("rst_pc", bus.instr_pc, 32'd0);
    apply_reset(1, 1'b1);
    expect_pc(32'h0);
    expect_pc(32'h4);
    expect_pc(32'h8);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check32("first_req", 32'(bus.imem_req), 32'd1);
    check32("first_addr", bus.imem_addr, 32'h0);
    @(negedge clk);
    check32("valid_c2", 32'(bus.instr_valid), 32'd0);
    @(negedge clk);
    check32("valid_c3", 32'(bus.instr_valid), 32'd1);
    wait_empty("stream");
    bus.instr_ready = 1'b0;

    // backpressure fills exactly BUF_DEPTH entries
    apply_reset(1, 1'b1);
    repeat (10) @(negedge clk);
    check32("bp_grants", 32'(grant_cnt), 32'd2);
    check32("bp_req", 32'(bus.imem_req), 32'd0);
    check32("bp_valid", 32'(bus.instr_valid), 32'd1);
    check32("bp_head_pc", bus.instr_pc, 32'h0);
    expect_pc(32'h0);
    expect_pc(32'h4);
    expect_pc(32'h8);
    expect_pc(32'hC);
    bus.instr_ready = 1'b1;
    wait_empty("backpressure");
    bus.instr_ready = 1'b0;

    // taken branch while a fetch is in flight
    apply_reset(3, 1'b1);
    expect_pc(32'h4);
    expect_pc(32'h8);
    bus.instr_ready = 1'b1;
    wait_grants(1);
    redirect(1'b1, 1'b0, 1'b0, 32'h10, 16'hFFFC, 26'h0, 32'h0);
    wait_empty("branch");
    bus.instr_ready = 1'b0;

    // jump beats branch in the same cycle
    apply_reset(3, 1'b1);
    expect_pc(32'hF000_0400);
    expect_pc(32'hF000_0404);
    bus.instr_ready = 1'b1;
    wait_grants(1);
    redirect(1'b1, 1'b1, 1'b0, 32'hF000_0040, 16'h0010, 26'h0000100, 32'h0);
    wait_empty("jump");
    bus.instr_ready = 1'b0;

    // jr target with low bits masked
    apply_reset(3, 1'b1);
    expect_pc(32'h200);
    expect_pc(32'h204);
    bus.instr_ready = 1'b1;
    wait_grants(1);
    redirect(1'b0, 1'b0, 1'b1, 32'h40, 16'h0, 26'h0, 32'h203);
    wait_empty("jr");
    bus.instr_ready = 1'b0;

    // redirect while the request is still ungranted
    apply_reset(1, 1'b0);
    repeat (5) @(negedge clk);
    check32("stall_req", 32'(bus.imem_req), 32'd1);
    check32("stall_addr", bus.imem_addr, 32'h0);
    redirect(1'b0, 1'b0, 1'b1, 32'h0, 16'h0, 26'h0, 32'h82);
    check32("redir_addr", bus.imem_addr, 32'h80);
    check32("redir_req", 32'(bus.imem_req), 32'd1);
    expect_pc(32'h80);
    expect_pc(32'h84);
    gnt_en = 1'b1;
    bus.instr_ready = 1'b1;
    wait_empty("ungranted");
    bus.instr_ready = 1'b0;
    check32("first_gnt_addr", first_gnt_addr, 32'h80);

    // reset during an outstanding fetch, with stray responses
    apply_reset(3, 1'b1);
    expect_pc(32'h0);
    bus.instr_ready = 1'b1;
    wait_empty("pre_reset");
    bus.instr_ready = 1'b0;
    wait_grants(2);
    check32("hold_valid", 32'(bus.instr_valid), 32'd0);
    check32("hold_instr", bus.instr, img(32'h0));
    rst = 1'b0;
    #1;
    check32("mid_rst_req", 32'(bus.imem_req), 32'd0);
    check32("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
    check32("mid_rst_instr", bus.instr, 32'd0);
    check32("mid_rst_pc", bus.instr_pc, 32'd0);
    repeat (5) @(negedge clk);
    exp_q.delete();
    lat       = 1;
    grant_cnt = 0;
    rst       = 1'b1;
    stray_cnt = 2;
    expect_pc(32'h0);
    expect_pc(32'h4);
    bus.instr_ready = 1'b1;
    wait_empty("post_reset");
    bus.instr_ready = 1'b0;

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
